// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_div_unit_if : E-stage HILO control bus between the decoder and the MDU
// Revision         : 1.0
// ---------------------------------------------------------------------------
interface mult_div_unit_if;
  logic        Start;
  logic [2:0]  MADop;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MADop, A, B, Req, input Busy, HI, LO);
  modport slave  (input Start, MADop, A, B, Req, output Busy, HI, LO);
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_div_unit : multi-cycle multiply/divide unit holding architectural HI/LO
//                 Optional macro MDU_DIV0_KEEP_EN drops divides by zero.
// Revision      : 1.0
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [31:0]      hi_tmp;
  logic [31:0]      lo_tmp;
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;
  logic             busy_reg;

  logic             is_mul;
  logic             is_div;
  logic             div_zero;
  logic             accept;
  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;

  always_comb begin
    is_mul   = (bus.MADop == OP_MULT) || (bus.MADop == OP_MULTU);
    is_div   = (bus.MADop == OP_DIV)  || (bus.MADop == OP_DIVU);
    div_zero = (bus.B == 32'd0);
    prod_s   = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    prod_u   = {32'd0, bus.A} * {32'd0, bus.B};
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    case (bus.MADop)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (div_zero) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = bus.A;
        end else if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
          // The one signed quotient that does not fit; wrap like the hardware does.
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = $signed(bus.A) / $signed(bus.B);
          res_hi = $signed(bus.A) % $signed(bus.B);
        end
      end
      OP_DIVU: begin
        if (div_zero) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = bus.A;
        end else begin
          res_lo = bus.A / bus.B;
          res_hi = bus.A % bus.B;
        end
      end
      default: ;
    endcase
`ifdef MDU_DIV0_KEEP_EN
    accept = (state == IDLE) && !bus.Req && bus.Start && (is_mul || (is_div && !div_zero));
`else
    accept = (state == IDLE) && !bus.Req && bus.Start && (is_mul || is_div);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      hi_tmp   <= 32'd0;
      lo_tmp   <= 32'd0;
      hi_reg   <= 32'd0;
      lo_reg   <= 32'd0;
      busy_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            hi_tmp   <= res_hi;
            lo_tmp   <= res_lo;
            count    <= is_mul ? MULT_LOAD : DIV_LOAD;
            busy_reg <= 1'b1;
            state    <= BUSY;
          end else if (!bus.Req && bus.MADop == OP_MTHI) begin
            hi_reg <= bus.A;
          end else if (!bus.Req && bus.MADop == OP_MTLO) begin
            lo_reg <= bus.A;
          end
        end
        BUSY: begin
          // Commit on the edge that closes the final busy cycle.
          if (count <= 1) begin
            hi_reg   <= hi_tmp;
            lo_reg   <= lo_tmp;
            count    <= '0;
            busy_reg <= 1'b0;
            state    <= IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy = busy_reg;
  assign bus.HI   = hi_reg;
  assign bus.LO   = lo_reg;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mult_div_unit : directed self-checking bench for mult_div_unit
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mult_div_unit_if bus ();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request on a falling edge, let one rising edge sample it, then idle the bus.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic start, input logic req);
    @(negedge clk);
    bus.Start = start;
    bus.MADop = op;
    bus.A     = a;
    bus.B     = b;
    bus.Req   = req;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.MADop = 3'd0;
    bus.Req   = 1'b0;
  endtask

  // Count falling edges with Busy high; note whether HI/LO moved while busy.
  task automatic measure_busy(input logic [31:0] old_hi, input logic [31:0] old_lo,
                              output int cycles, output logic held);
    cycles = 0;
    held   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.Busy !== 1'b1) break;
      cycles++;
      if (bus.HI !== old_hi || bus.LO !== old_lo) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      errors++;
      $display("FAIL reset: busy=%b hi=%h lo=%h expected 0/0/0", bus.Busy, bus.HI, bus.LO);
    end
  endtask

  task automatic test_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_cycles,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int   cyc;
    logic held;
    logic [31:0] old_hi, old_lo;
    old_hi = bus.HI;
    old_lo = bus.LO;
    issue(op, a, b, 1'b1, 1'b0);
    measure_busy(old_hi, old_lo, cyc, held);
    checks++;
    if (cyc != exp_cycles) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, cyc, exp_cycles);
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL %s hilo_held: HI/LO changed while busy", name);
    end
    checks++;
    if (bus.HI !== exp_hi || bus.LO !== exp_lo) begin
      errors++;
      $display("FAIL %s result: hi=%h lo=%h expected hi=%h lo=%h", name, bus.HI, bus.LO, exp_hi, exp_lo);
    end
  endtask

  task automatic test_mt_and_req();
    logic [31:0] old_lo, old_hi;
    old_lo = bus.LO;
    issue(3'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    checks++;
    if (bus.HI !== 32'h1234_5678 || bus.LO !== old_lo || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi: hi=%h lo=%h busy=%b expected hi=12345678 lo=%h busy=0", bus.HI, bus.LO, bus.Busy, old_lo);
    end
    issue(3'd6, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
    checks++;
    if (bus.LO !== 32'hCAFE_F00D || bus.HI !== 32'h1234_5678) begin
      errors++;
      $display("FAIL mtlo: hi=%h lo=%h expected hi=12345678 lo=cafef00d", bus.HI, bus.LO);
    end
    old_hi = bus.HI;
    old_lo = bus.LO;
    issue(3'd5, 32'hAAAA_5555, 32'd0, 1'b0, 1'b1);
    checks++;
    if (bus.HI !== old_hi) begin
      errors++;
      $display("FAIL mthi_req_block: hi=%h expected %h", bus.HI, old_hi);
    end
    issue(3'd1, 32'd3, 32'd4, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== old_hi || bus.LO !== old_lo) begin
      errors++;
      $display("FAIL start_req_block: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h", bus.Busy, bus.HI, bus.LO, old_hi, old_lo);
    end
    issue(3'd7, 32'd3, 32'd4, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== old_hi || bus.LO !== old_lo) begin
      errors++;
      $display("FAIL start_bad_op: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h", bus.Busy, bus.HI, bus.LO, old_hi, old_lo);
    end
  endtask

  task automatic test_div0();
`ifdef MDU_DIV0_KEEP_EN
    test_op("divu_zero", 3'd4, 32'hDEAD_BEEF, 32'd0, 0, bus.HI, bus.LO);
    test_op("div_zero",  3'd3, 32'h0000_0123, 32'd0, 0, bus.HI, bus.LO);
`else
    test_op("divu_zero", 3'd4, 32'hDEAD_BEEF, 32'd0, 10, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    test_op("div_zero",  3'd3, 32'h0000_0123, 32'd0, 10, 32'h0000_0123, 32'hFFFF_FFFF);
`endif
  endtask

  task automatic test_reset_abort();
    issue(3'd1, 32'd5, 32'd7, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before: busy=%b expected 1", bus.Busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      errors++;
      $display("FAIL abort_reset: busy=%b hi=%h lo=%h expected 0/0/0", bus.Busy, bus.HI, bus.LO);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      errors++;
      $display("FAIL abort_no_commit: busy=%b hi=%h lo=%h expected 0/0/0", bus.Busy, bus.HI, bus.LO);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.Start = 1'b0;
    bus.MADop = 3'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    bus.Req   = 1'b0;

    test_reset();
    test_op("mult",      3'd1, 32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    test_op("multu",     3'd2, 32'hFFFF_FFFF, 32'd2,        5,  32'h0000_0001, 32'hFFFF_FFFE);
    test_op("div",       3'd3, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    test_op("div_ovf",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    test_op("divu",      3'd4, 32'd100,       32'd7,        10, 32'd2,         32'd14);
    test_op("div_neg_b", 3'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD);
    test_mt_and_req();
    test_div0();
    test_reset_abort();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
